// File: rtl/btn_counter_bcd_display.sv
// Push-button up/down counter: synchronise, debounce, count, shift-add-3 to BCD, 7-segment out.
// Optional hold-to-repeat events are built when COUNTER_AUTO_REPEAT_EN is defined.
module btn_counter_bcd_display #(
  parameter int N          = 6,
  parameter int DIGITS     = 2,
  parameter int DEB_CYCLES = 4,
  parameter int WRAP       = 0,
  parameter int RPT_DELAY  = 16,
  parameter int RPT_PERIOD = 8
) (
  input  logic                  clk,
  input  logic                  btn_reset,
  input  logic                  btn_increment,
  input  logic                  btn_decrement,
  output logic [N-1:0]          count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy
);

  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BW   = $clog2(N + 1);
  localparam int BCDW = 4 * DIGITS;
  localparam logic [N-1:0] MAX_CNT = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10
  } state_t;

  if (N < 1 || DIGITS < 1 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("btn_counter_bcd_display: N, DIGITS and DEB_CYCLES must be >= 1");
  end
  if (10 ** DIGITS <= 2 ** N - 1) begin : g_bad_digits
    $error("btn_counter_bcd_display: DIGITS too small for N");
  end
  if (RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_rpt
    $error("btn_counter_bcd_display: RPT_DELAY and RPT_PERIOD must be >= 1");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0000001;
      4'd1:    p = 7'b1001111;
      4'd2:    p = 7'b0010010;
      4'd3:    p = 7'b0000110;
      4'd4:    p = 7'b1001100;
      4'd5:    p = 7'b0100100;
      4'd6:    p = 7'b0100000;
      4'd7:    p = 7'b0001111;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0000100;
      default: p = 7'b0000001;
    endcase
    return p;
  endfunction

  function automatic logic [7*DIGITS-1:0] encode_all(input logic [BCDW-1:0] b);
    logic [7*DIGITS-1:0] r;
    r = {(7*DIGITS){1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = seg7(b[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [BCDW-1:0] add3_all(input logic [BCDW-1:0] v);
    logic [BCDW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Bit 0 is the increment button, bit 1 the decrement button.
  logic [1:0]          btn_raw_s;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d, deb_prev_q;
  logic [1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]          press_s, evt_s;

  logic [N-1:0]        count_q, count_d;
  state_t              state_q, state_d;
  logic                pending_q, pending_d, pending_base_s;
  logic [N-1:0]        shreg_q, shreg_d;
  logic [BCDW-1:0]     bcd_q, bcd_d, bcd_adj_s;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                busy_q, busy_d;

  assign btn_raw_s = {btn_decrement, btn_increment};
  assign press_s   = deb_prev_q & ~deb_q;
  assign bcd_adj_s = add3_all(bcd_q);

  // Debounce: count consecutive cycles where the synchronised level disagrees.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = {(2*DW){1'b0}};
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        deb_cnt_d[b] = {DW{1'b0}};
      end else if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
        deb_d[b]     = ~deb_q[b];
        deb_cnt_d[b] = {DW{1'b0}};
      end else begin
        deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
      end
    end
  end

`ifdef COUNTER_AUTO_REPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [1:0]         rpt_phase_q, rpt_phase_d, rpt_s;

  // Hold timer: first repeat after RPT_DELAY held cycles, then every RPT_PERIOD.
  always_comb begin
    rpt_cnt_d   = {(2*RW){1'b0}};
    rpt_phase_d = 2'b00;
    rpt_s       = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (deb_q[b] || press_s[b]) begin
        rpt_cnt_d[b]   = {RW{1'b0}};
        rpt_phase_d[b] = 1'b0;
      end else if (!rpt_phase_q[b]) begin
        if (rpt_cnt_q[b] == RW'(RPT_DELAY - 1)) begin
          rpt_s[b]       = 1'b1;
          rpt_phase_d[b] = 1'b1;
          rpt_cnt_d[b]   = {RW{1'b0}};
        end else begin
          rpt_phase_d[b] = 1'b0;
          rpt_cnt_d[b]   = rpt_cnt_q[b] + RW'(1);
        end
      end else begin
        rpt_phase_d[b] = 1'b1;
        if (rpt_cnt_q[b] == RW'(RPT_PERIOD - 1)) begin
          rpt_s[b]     = 1'b1;
          rpt_cnt_d[b] = {RW{1'b0}};
        end else begin
          rpt_cnt_d[b] = rpt_cnt_q[b] + RW'(1);
        end
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk) begin
    if (!btn_reset) begin
      rpt_cnt_q   <= {(2*RW){1'b0}};
      rpt_phase_q <= 2'b00;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  assign evt_s = press_s | rpt_s;
`else
  assign evt_s = press_s;
`endif

  // Counter update; simultaneous inc and dec events cancel.
  always_comb begin
    count_d = count_q;
    if (evt_s[0] && !evt_s[1]) begin
      if (count_q != MAX_CNT) begin
        count_d = count_q + N'(1);
      end else if (WRAP != 0) begin
        count_d = {N{1'b0}};
      end else begin
        count_d = count_q;
      end
    end else if (evt_s[1] && !evt_s[0]) begin
      if (count_q != {N{1'b0}}) begin
        count_d = count_q - N'(1);
      end else if (WRAP != 0) begin
        count_d = MAX_CNT;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Conversion FSM; a count change at any time re-arms pending.
  always_comb begin
    state_d        = state_q;
    pending_base_s = pending_q;
    shreg_d        = shreg_q;
    bcd_d          = bcd_q;
    bit_cnt_d      = bit_cnt_q;
    seg_d          = seg_q;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d        = SHIFT;
          shreg_d        = count_q;
          bcd_d          = {BCDW{1'b0}};
          bit_cnt_d      = {BW{1'b0}};
          pending_base_s = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d     = {bcd_adj_s[BCDW-2:0], shreg_q[N-1]};
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(N - 1)) begin
          state_d = LOAD;
        end else begin
          state_d = SHIFT;
        end
      end
      LOAD: begin
        seg_d   = encode_all(bcd_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pending_d = (count_d != count_q) ? 1'b1 : pending_base_s;
    busy_d    = (state_d == SHIFT);
  end

  // All state registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (!btn_reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      deb_cnt_q  <= {(2*DW){1'b0}};
      count_q    <= MAX_CNT;
      state_q    <= IDLE;
      pending_q  <= 1'b1;
      shreg_q    <= {N{1'b0}};
      bcd_q      <= {BCDW{1'b0}};
      bit_cnt_q  <= {BW{1'b0}};
      seg_q      <= {(7*DIGITS){1'b1}};
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      count_q    <= count_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      seg_q      <= seg_d;
      busy_q     <= busy_d;
    end
  end

  assign count = count_q;
  assign seg   = seg_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_btn_counter_bcd_display.sv
// Bench for btn_counter_bcd_display: a saturating and a wrapping instance share the same buttons.
module tb_btn_counter_bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        btn_reset, btn_increment, btn_decrement;
  logic [5:0]  count0, count1;
  logic [13:0] seg0, seg1;
  logic        busy0, busy1;

  btn_counter_bcd_display #(.N(6), .DIGITS(2), .DEB_CYCLES(4), .WRAP(0)) dut (
    .clk(clk), .btn_reset(btn_reset), .btn_increment(btn_increment),
    .btn_decrement(btn_decrement), .count(count0), .seg(seg0), .busy(busy0));

  btn_counter_bcd_display #(.N(6), .DIGITS(2), .DEB_CYCLES(4), .WRAP(1)) dut_w (
    .clk(clk), .btn_reset(btn_reset), .btn_increment(btn_increment),
    .btn_decrement(btn_decrement), .count(count1), .seg(seg1), .busy(busy1));

  typedef struct {
    string      name;
    logic       inc;
    logic       dec;
    int         hold;
    logic [5:0] exp0;
    logic [5:0] exp1;
  } vec_t;

  typedef struct {
    logic [5:0] c0;
    logic [5:0] c1;
    string      name;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m0, m1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] seg_of(input int v);
    return {pat(v / 10), pat(v % 10)};
  endfunction

  function automatic int model(input int c, input bit inc, input bit dec, input bit wrap);
    if (inc && !dec) return (c == 63) ? (wrap ? 0 : 63) : c + 1;
    else if (dec && !inc) return (c == 0) ? (wrap ? 63 : 0) : c - 1;
    else return c;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic inc, input logic dec, input int hold,
                       output bit saw0, output bit saw1);
    saw0 = 1'b0;
    saw1 = 1'b0;
    btn_increment = ~inc;
    btn_decrement = ~dec;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      saw0 |= busy0;
      saw1 |= busy1;
    end
    btn_increment = 1'b1;
    btn_decrement = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      saw0 |= busy0;
      saw1 |= busy1;
    end
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int t = 0;
    while (quiet < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (!busy0 && !busy1) quiet++;
      else quiet = 0;
    end
    check({name, "_idle"}, 32'(quiet >= 3), 32'd1);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got no queued entry expected one");
    end else begin
      e = sb.pop_front();
      check({e.name, "_count0"}, 32'(count0), 32'(e.c0));
      check({e.name, "_count1"}, 32'(count1), 32'(e.c1));
      check({e.name, "_seg0"},   32'(seg0),   32'(seg_of(int'(e.c0))));
      check({e.name, "_seg1"},   32'(seg1),   32'(seg_of(int'(e.c1))));
    end
  endtask

  task automatic run_vec(input int i);
    bit s0, s1;
    sb.push_back('{vecs[i].exp0, vecs[i].exp1, vecs[i].name});
    drive(vecs[i].inc, vecs[i].dec, vecs[i].hold, s0, s1);
    wait_idle(vecs[i].name);
    check({vecs[i].name, "_conv0"}, 32'(s0), 32'(vecs[i].exp0 != 6'(m0)));
    check({vecs[i].name, "_conv1"}, 32'(s1), 32'(vecs[i].exp1 != 6'(m1)));
    score();
    m0 = int'(vecs[i].exp0);
    m1 = int'(vecs[i].exp1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int nb;
    bit s0, s1;
    vecs[0] = '{"dec_press",   1'b0, 1'b1, 10, 6'd62, 6'd62};
    vecs[1] = '{"glitch",      1'b0, 1'b1,  2, 6'd62, 6'd62};
    vecs[2] = '{"inc_press",   1'b1, 1'b0, 10, 6'd63, 6'd63};
    vecs[3] = '{"inc_at_max",  1'b1, 1'b0, 10, 6'd63, 6'd0};
    vecs[4] = '{"dec_from_0w", 1'b0, 1'b1, 10, 6'd62, 6'd63};
    vecs[5] = '{"both",        1'b1, 1'b1, 10, 6'd62, 6'd63};
    vecs[6] = '{"inc_again",   1'b1, 1'b0, 10, 6'd63, 6'd0};
    vecs[7] = '{"dec_again",   1'b0, 1'b1, 10, 6'd62, 6'd63};
    vecs[8] = '{"dec_sat0",    1'b0, 1'b1, 10, 6'd0,  6'd0};
    vecs[9] = '{"dec_at_zero", 1'b0, 1'b1, 10, 6'd0,  6'd63};

    btn_reset = 1'b0;
    btn_increment = 1'b1;
    btn_decrement = 1'b1;
    cyc(2);
    check("rst_count0", 32'(count0), 32'd63);
    check("rst_count1", 32'(count1), 32'd63);
    check("rst_seg0",   32'(seg0),   32'h3FFF);
    check("rst_busy0",  32'(busy0),  32'd0);
    check("rst_busy1",  32'(busy1),  32'd0);
    btn_reset = 1'b1;
    nb = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy0) nb++;
      if (i == 7) check("seg_before_load", 32'(seg0), 32'h3FFF);
      if (i == 8) check("seg_latency", 32'(seg0), 32'(seg_of(63)));
    end
    check("busy_cycles", 32'(nb), 32'd6);
    check("post_rst_seg1", 32'(seg1), 32'(seg_of(63)));
    m0 = 63;
    m1 = 63;

    for (int i = 0; i < 8; i++) run_vec(i);

    for (int k = 0; k < 62; k++) begin
      m0 = model(m0, 1'b0, 1'b1, 1'b0);
      m1 = model(m1, 1'b0, 1'b1, 1'b1);
      sb.push_back('{6'(m0), 6'(m1), "dec_walk"});
      drive(1'b0, 1'b1, 10, s0, s1);
      wait_idle("dec_walk");
      score();
    end

    for (int i = 8; i < 10; i++) run_vec(i);

`ifdef COUNTER_AUTO_REPEAT_EN
    for (int k = 0; k < 5; k++) begin
      m0 = model(m0, 1'b1, 1'b0, 1'b0);
      m1 = model(m1, 1'b1, 1'b0, 1'b1);
    end
    sb.push_back('{6'(m0), 6'(m1), "auto_repeat"});
    drive(1'b1, 1'b0, 44, s0, s1);
    wait_idle("auto_repeat");
    score();
`endif

    // Press lands on the last SHIFT edge of the post-reset conversion.
    btn_reset = 1'b0;
    cyc(1);
    btn_reset = 1'b1;
    btn_decrement = 1'b0;
    sb.push_back('{6'd62, 6'd62, "chg_in_shift"});
    cyc(6);
    check("pre_event_count", 32'(count0), 32'd63);
    check("pre_event_busy",  32'(busy0),  32'd1);
    cyc(1);
    check("event_latency0", 32'(count0), 32'd62);
    check("event_latency1", 32'(count1), 32'd62);
    cyc(1);
    btn_decrement = 1'b1;
    cyc(14);
    wait_idle("chg_in_shift");
    score();

    // Reset while a conversion is mid-SHIFT.
    btn_decrement = 1'b0;
    cyc(10);
    check("mid_shift_busy",  32'(busy0),  32'd1);
    check("mid_shift_count", 32'(count0), 32'd61);
    btn_decrement = 1'b1;
    btn_reset = 1'b0;
    cyc(1);
    check("midrst_count0", 32'(count0), 32'd63);
    check("midrst_count1", 32'(count1), 32'd63);
    check("midrst_seg0",   32'(seg0),   32'h3FFF);
    check("midrst_seg1",   32'(seg1),   32'h3FFF);
    check("midrst_busy0",  32'(busy0),  32'd0);
    btn_reset = 1'b1;
    sb.push_back('{6'd63, 6'd63, "after_midrst"});
    cyc(14);
    wait_idle("after_midrst");
    score();

    // Two quick decrement presses; the second change arrives before the display settles.
    sb.push_back('{6'd61, 6'd61, "two_decs"});
    btn_decrement = 1'b0;
    cyc(4);
    btn_decrement = 1'b1;
    cyc(4);
    btn_decrement = 1'b0;
    cyc(8);
    btn_decrement = 1'b1;
    cyc(14);
    wait_idle("two_decs");
    score();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
